// File: rtl/tagged_word_if.sv
// Data/id word interface bundle: upstream push side, downstream pop side,
// tag restart and occupancy. The slave modport is the transmitter's view.
interface tagged_word_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 32,
  parameter int DEPTH      = 4
);
  localparam int LEVEL_WIDTH = $clog2(DEPTH) + 1;

  logic                   in_valid;
  logic [DATA_WIDTH-1:0]  in_data;
  logic                   in_ready;
  logic                   out_valid;
  logic [DATA_WIDTH-1:0]  data;
  logic [ID_WIDTH-1:0]    id;
  logic                   out_ready;
  logic                   id_clear;
  logic [LEVEL_WIDTH-1:0] level;

  modport master (
    output in_valid, in_data, out_ready, id_clear,
    input  in_ready, out_valid, data, id, level
  );

  modport slave (
    input  in_valid, in_data, out_ready, id_clear,
    output in_ready, out_valid, data, id, level
  );
endinterface

// File: rtl/tagged_word_tx.sv
// Tagged word transmitter: stamps each accepted payload with a wrapping ID,
// buffers {data, id} pairs in a small FIFO and presents the head downstream.
module tagged_word_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 32,
  parameter int DEPTH      = 4
) (
  input  logic         clk,
  input  logic         rst,
  tagged_word_if.slave bus
);
  localparam int PTR_WIDTH   = $clog2(DEPTH);
  localparam int LEVEL_WIDTH = PTR_WIDTH + 1;

  // Storage is read combinationally so a word pushed into an empty FIFO
  // is visible at the outputs right after the push edge.
  logic [DATA_WIDTH-1:0]  mem_data [DEPTH];
  logic [ID_WIDTH-1:0]    mem_id   [DEPTH];

  logic [PTR_WIDTH-1:0]   wr_ptr_reg;
  logic [PTR_WIDTH-1:0]   rd_ptr_reg;
  logic [LEVEL_WIDTH-1:0] level_reg;
  logic [LEVEL_WIDTH-1:0] level_next;
  logic [ID_WIDTH-1:0]    next_id_reg;
  logic [ID_WIDTH-1:0]    next_id_next;
  logic [ID_WIDTH-1:0]    tag;
  logic [DEPTH-1:0]       wr_en;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;

  // Handshake flags come only from registered occupancy.
  assign full  = (level_reg == LEVEL_WIDTH'(DEPTH));
  assign empty = (level_reg == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = !empty && bus.out_ready;

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.level     = level_reg;
  // Gate the head so idle outputs never expose stale memory.
  assign bus.data      = empty ? '0 : mem_data[rd_ptr_reg];
  assign bus.id        = empty ? '0 : mem_id[rd_ptr_reg];

  // Per-entry write enable decode from the write pointer.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_reg == PTR_WIDTH'(gi));
    end
  endgenerate

  // Tag for a push this cycle (restart overrides the counter) and the
  // next occupancy / counter values.
  always_comb begin
    tag          = bus.id_clear ? '0 : next_id_reg;
    next_id_next = next_id_reg;
    level_next   = level_reg;
    if (push) begin
      next_id_next = tag + 1'b1;
    end else if (bus.id_clear) begin
      next_id_next = '0;
    end
    if (push && !pop) begin
      level_next = level_reg + 1'b1;
    end else if (pop && !push) begin
      level_next = level_reg - 1'b1;
    end
  end

  // Pointer, occupancy and tag counter registers; reset discards contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      next_id_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg   <= level_next;
      next_id_reg <= next_id_next;
    end
  end

  // Entry storage write; no reset needed since outputs are gated by level.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst && wr_en[i]) begin
        mem_data[i] <= bus.in_data;
        mem_id[i]   <= tag;
      end
    end
  end
endmodule

// File: tb/tb_tagged_word_tx.sv
// Self-checking bench for tagged_word_tx: directed scenarios followed by
// random traffic, compared against a queue-based model. A second instance
// built with 4-bit tags shares the stimulus to exercise tag wrap.
module tb_tagged_word_tx;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  tagged_word_if #(.DATA_WIDTH(DW), .ID_WIDTH(32), .DEPTH(DEPTH)) b ();
  tagged_word_if #(.DATA_WIDTH(DW), .ID_WIDTH(4),  .DEPTH(DEPTH)) bw ();

  tagged_word_tx #(.DATA_WIDTH(DW), .ID_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  tagged_word_tx #(.DATA_WIDTH(DW), .ID_WIDTH(4), .DEPTH(DEPTH)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bw)
  );

  assign bw.in_valid  = b.in_valid;
  assign bw.in_data   = b.in_data;
  assign bw.out_ready = b.out_ready;
  assign bw.id_clear  = b.id_clear;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of accepted words and the tag counter.
  typedef struct {
    logic [DW-1:0] d;
    logic [31:0]   i;
  } ent_t;
  ent_t        q[$];
  logic [31:0] nid;
  int          cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic verify();
    logic [DW-1:0] ed;
    logic [31:0]   ei;
    ed = '0;
    ei = '0;
    if (q.size() != 0) begin
      ed = q[0].d;
      ei = q[0].i;
    end
    check($sformatf("c%0d level", cyc), 64'(b.level), 64'(q.size()));
    check($sformatf("c%0d in_ready", cyc), 64'(b.in_ready), 64'(q.size() != DEPTH));
    check($sformatf("c%0d out_valid", cyc), 64'(b.out_valid), 64'(q.size() != 0));
    check($sformatf("c%0d data", cyc), 64'(b.data), 64'(ed));
    check($sformatf("c%0d id", cyc), 64'(b.id), 64'(ei));
    check($sformatf("c%0d id4", cyc), 64'(bw.id), 64'(ei[3:0]));
    check($sformatf("c%0d data4", cyc), 64'(bw.data), 64'(ed));
  endtask

  task automatic cycle(input logic iv, input logic [DW-1:0] din, input logic ordy, input logic clr);
    logic        do_push;
    logic        do_pop;
    logic [31:0] t;
    b.in_valid  = iv;
    b.in_data   = din;
    b.out_ready = ordy;
    b.id_clear  = clr;
    do_push = iv && (q.size() < DEPTH);
    do_pop  = ordy && (q.size() > 0);
    @(posedge clk);
    t = clr ? 32'd0 : nid;
    if (do_pop) begin
      $display("cyc %0d pop data=%02h id=%0d", cyc, q[0].d, q[0].i);
      void'(q.pop_front());
    end
    if (do_push) begin
      q.push_back('{d: din, i: t});
      nid = t + 32'd1;
    end else if (clr) begin
      nid = 32'd0;
    end
    #1;
    verify();
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      b.in_valid  = 1'($urandom);
      b.in_data   = DW'($urandom);
      b.out_ready = 1'($urandom);
      b.id_clear  = 1'($urandom);
      @(posedge clk);
      q.delete();
      nid = 32'd0;
      #1;
      verify();
      cyc++;
      @(negedge clk);
    end
    rst = 1'b0;
    $display("cyc %0d reset released", cyc);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    nid   = 32'd0;
    rst   = 1'b1;
    b.in_valid  = 1'b0;
    b.in_data   = '0;
    b.out_ready = 1'b0;
    b.id_clear  = 1'b0;

    // Reset then a single word through.
    do_reset(2);
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill with backpressure; fifth word waits until space frees.
    do_reset(1);
    for (int v = 1; v <= 5; v++) cycle(1'b1, 8'(v), 1'b0, 1'b0);
    cycle(1'b1, 8'h05, 1'b1, 1'b0);
    cycle(1'b1, 8'h05, 1'b1, 1'b0);
    repeat (5) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Sustained streaming.
    do_reset(1);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Tag restart combined with a push, with older entries still buffered.
    do_reset(1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h30, 1'b0, 1'b0);
    cycle(1'b1, 8'h31, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b1);
    cycle(1'b1, 8'h78, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Tag wrap on the 4-bit instance.
    do_reset(1);
    for (int i = 0; i < 18; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset with words buffered.
    do_reset(1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
    do_reset(1);
    cycle(1'b1, 8'h42, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic in phases of varying downstream pressure.
    for (int i = 0; i < 400; i++) begin
      logic iv;
      logic ordy;
      logic clr;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      clr  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
      end else begin
        cycle(iv, DW'($urandom), ordy, clr);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
